// File: rtl/uart_pkg.sv
// uart_pkg: FSM states, register offsets and STATUS bit positions shared by mmio_uart_tx.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
   localparam logic [31:0] TXDATA_OFS = 32'h0;
   localparam logic [31:0] STATUS_OFS = 32'h4;
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO, power-of-2 depth, show-ahead read, async active-high reset.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   // full is judged on the pre-pop count, so a push colliding with a pop at full is dropped
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus UART transmitter (TXDATA/STATUS window, FIFO, 8N1 serialiser).
// Defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits (8E1).
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000,
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_data,
   input  logic        wea,
   output logic [31:0] rd_data,
   output logic        tx,
   output logic        tx_busy
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   logic [7:0]                  fifo_dout;
   logic                        fifo_full, fifo_empty, pop;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        wr_tx, wr_st, ovf, unused;
   logic [31:0]                 status;
   uart_state_t                 state, state_n;
   logic [CW-1:0]               cnt, cnt_n;
   logic [2:0]                  bit_idx, bit_n;
   logic [7:0]                  shift, shift_n;
   logic                        tx_n;
   assign wr_tx  = wea && m_addr == BASE_ADDR + TXDATA_OFS;
   assign wr_st  = wea && m_addr == BASE_ADDR + STATUS_OFS;
   assign unused = ^{m_data[31:8], fifo_count};
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_tx),
      .pop   (pop),
      .din   (m_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );
   always_comb begin
      status           = '0;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_BUSY]  = tx_busy;
      status[ST_OVF]   = ovf;
   end
   assign rd_data = (m_addr == BASE_ADDR + STATUS_OFS) ? status : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) ovf <= 1'b0;
      else if (wr_tx && fifo_full) ovf <= 1'b1;
      else if (wr_st && m_data[ST_OVF]) ovf <= 1'b0;
   // data bits rotate rather than shift so the byte is intact again for the parity bit
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      shift_n = shift;
      pop     = 1'b0;
      if (state == IDLE) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_dout;
            cnt_n   = DIV_LAST;
            state_n = START;
         end
      end else if (cnt != '0) begin
         cnt_n = cnt - 1'b1;
      end else begin
         cnt_n = DIV_LAST;
         case (state)
            START: state_n = DATA;
            DATA: begin
               shift_n = {shift[0], shift[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
            end
            PARITY: state_n = STOP;
            STOP: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = fifo_dout;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      tx_n = (state_n == START)  ? 1'b0 :
             (state_n == DATA)   ? shift_n[0] :
             (state_n == PARITY) ? ^shift_n : 1'b1;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         tx      <= tx_n;
         tx_busy <= state_n != IDLE;
      end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register-table vectors, hand-timed frame/overflow/reset sequences and
// randomized bursts, all checked by a serial-line decoder against expected byte queues.
module tb_mmio_uart_tx;
   localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CLK_DIV;
   localparam logic [31:0] A_TX = 32'h3000;
   localparam logic [31:0] A_ST = 32'h3004;

   logic clk, rst, wea, tx, tx_busy;
   logic [31:0] m_addr, m_data, rd_data;
   int n_cmp = 0, n_err = 0, cyc = 0, last_w;
   logic [7:0] dec_q[$];
   int st_q[$];
   logic [7:0] exp_q[$];

   mmio_uart_tx #(.BASE_ADDR(32'h3000), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .m_addr(m_addr), .m_data(m_data), .wea(wea),
      .rd_data(rd_data), .tx(tx), .tx_busy(tx_busy));

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      m_addr = a; m_data = d; wea = 1;
      @(posedge clk);
      #1 wea = 0; m_addr = A_ST; last_w = cyc;
      #1;
   endtask

   task automatic wait_idle(input int max);
      logic done;
      done = 0;
      m_addr = A_ST;
      for (int i = 0; i < max && !done; i++) begin
         @(negedge clk);
         done = !tx_busy && rd_data[1];
      end
      chk("idle_wait", {31'd0, done}, 1);
   endtask

   task automatic sync_to(input int target);
      for (int i = 0; i < 4 * FRAME && cyc != target; i++) @(negedge clk);
      chk("cycle_sync", cyc, target);
   endtask

   task automatic cmp_stream(input string nm);
      chk({nm, "_count"}, dec_q.size(), exp_q.size());
      foreach (exp_q[i])
         chk($sformatf("%s_byte%0d", nm, i), (i < dec_q.size()) ? {24'd0, dec_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
   endtask

   // serial-line decoder: every bit must hold CLK_DIV cycles; a reset abandons the frame
   logic mprev, mab, mok;
   logic [10:0] mbits;
   int mst;
   initial begin
      mprev = 1;
      forever begin
         @(negedge clk);
         if (!rst && mprev && !tx) begin
            mst = cyc; mab = 0; mok = 1; mbits = '0;
            for (int j = 0; j < NB && !mab; j++) begin
               mbits[j] = tx;
               for (int k = 1; k < CLK_DIV && !mab; k++) begin
                  @(negedge clk);
                  if (rst) mab = 1;
                  else if (tx !== mbits[j]) mok = 0;
               end
               if (j < NB - 1 && !mab) begin
                  @(negedge clk);
                  if (rst) mab = 1;
               end
            end
            if (!mab) begin
               chk("frame_shape", {29'd0, mok, mbits[0], mbits[NB-1]}, 32'h5);
`ifdef UART_TX_PARITY_EN
               chk("parity_bit", {31'd0, mbits[9]}, {31'd0, ^mbits[8:1]});
`endif
               dec_q.push_back(mbits[8:1]);
               st_q.push_back(mst);
            end
         end
         mprev = tx;
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] raddr;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[10];

   logic [31:0] noise[5];
   int w, n;
   logic [7:0] b;

   initial begin
      tbl[0] = '{1'b0, A_ST,       32'h0,   A_ST,       32'h2};
      tbl[1] = '{1'b0, A_ST,       32'h0,   A_TX,       32'h0};
      tbl[2] = '{1'b1, 32'h2000,   32'h1,   32'h2000,   32'h0};
      tbl[3] = '{1'b0, A_ST,       32'h0,   A_ST,       32'h2};
      tbl[4] = '{1'b1, A_ST,       32'hF7,  A_ST,       32'h2};
      tbl[5] = '{1'b1, 32'h3008,   32'h5A,  32'h3008,   32'h0};
      tbl[6] = '{1'b1, A_TX,       32'h1A5, A_ST,       32'h0};
      tbl[7] = '{1'b0, A_ST,       32'h0,   A_ST,       32'h6};
      tbl[8] = '{1'b1, 32'h2FFC,   32'h33,  A_ST,       32'h6};
      tbl[9] = '{1'b1, A_TX,       32'h3C,  A_ST,       32'h4};
      noise = '{32'h2000, A_ST, 32'h3008, 32'h2FFC, 32'h13000};

      rst = 1; wea = 0; m_addr = A_ST; m_data = 0;
      #12;
      chk("rst_tx", {31'd0, tx}, 1);
      chk("rst_busy", {31'd0, tx_busy}, 0);
      chk("rst_status", rd_data, 32'h2);
      @(negedge clk); rst = 0;

      // register window vectors
      foreach (tbl[i]) begin
         @(negedge clk);
         wea = tbl[i].we; m_addr = tbl[i].addr; m_data = tbl[i].data;
         @(posedge clk);
         #1 wea = 0; m_addr = tbl[i].raddr;
         #1 chk($sformatf("vec%0d", i), rd_data, tbl[i].exp);
      end
      exp_q = '{8'hA5, 8'h3C};
      wait_idle(4 * FRAME);
      cmp_stream("table_frames");

      // single 0x55 frame: latency and exact length
      dec_q.delete(); st_q.delete();
      wr(A_TX, 32'h55);
      w = last_w;
      sync_to(w + FRAME);
      chk("busy_last_cycle", {31'd0, tx_busy}, 1);
      @(negedge clk);
      chk("busy_after_frame", {31'd0, tx_busy}, 0);
      chk("tx_idle_high", {31'd0, tx}, 1);
      chk("latency", (st_q.size() > 0) ? st_q[0] - w : -1, 1);
      exp_q = '{8'h55};
      cmp_stream("x55");

      // overflow: one frame in flight, then 17 back-to-back stores
      dec_q.delete(); st_q.delete(); exp_q.delete();
      wr(A_TX, 32'hAA);
      w = last_w;
      exp_q.push_back(8'hAA);
      for (int i = 0; i < 17; i++) begin
         wr(A_TX, i);
         if (i < 16) exp_q.push_back(8'(i));
      end
      chk("ovf_status", rd_data, 32'hD);
      wr(A_ST, 32'h7);
      chk("ovf_sticky", rd_data, 32'hD);
      wr(A_ST, 32'h8);
      chk("ovf_cleared", rd_data, 32'h5);
      // push on the very edge the FSM pops a full FIFO must be dropped
      sync_to(w + FRAME);
      m_addr = A_TX; m_data = 32'h77; wea = 1;
      @(posedge clk);
      #1 wea = 0; m_addr = A_ST;
      #1 chk("pop_full_drop", rd_data, 32'hC);
      wr(A_ST, 32'h8);
      wait_idle(20 * FRAME);
      cmp_stream("burst");
      for (int i = 1; i < st_q.size(); i++)
         chk($sformatf("gap%0d", i), st_q[i] - st_q[i-1], FRAME);

      // randomized bursts with interleaved out-of-window stores
      for (int r = 0; r < 6; r++) begin
         dec_q.delete(); st_q.delete(); exp_q.delete();
         n = $urandom_range(1, 15);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) wr(noise[$urandom_range(0, 4)], $urandom);
            b = 8'($urandom);
            wr(A_TX, {$urandom_range(0, 255), b} & 32'hFFFF);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         wait_idle(20 * FRAME);
         cmp_stream($sformatf("rand%0d", r));
         chk($sformatf("rand%0d_status", r), rd_data, 32'h2);
      end

      // reset in the middle of the second of three frames
      dec_q.delete(); st_q.delete();
      wr(A_TX, 32'h11); w = last_w;
      wr(A_TX, 32'h22);
      wr(A_TX, 32'h33);
      sync_to(w + 1 + FRAME + CLK_DIV + 3);
      #2 rst = 1;
      #1;
      chk("midrst_tx", {31'd0, tx}, 1);
      chk("midrst_busy", {31'd0, tx_busy}, 0);
      chk("midrst_status", rd_data, 32'h2);
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (3 * FRAME) @(negedge clk);
      exp_q = '{8'h11};
      cmp_stream("midrst");
      chk("midrst_tx_after", {31'd0, tx}, 1);
      chk("midrst_status_after", rd_data, 32'h2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
